ov7670_config_sequencer: RTL
============================

# ov7670_config_sequencer

Walks the OV7670 static configuration ROM from address 0 and turns each 16-bit entry into one SCCB register write, inserting a settle delay on the delay marker and stopping at the end marker. It sits between the configuration ROM (upstream, 1-cycle registered read) and the SCCB master (downstream, start/ready handshake), and reports completion to the camera bring-up logic.

## Interface
- CLK_FREQ, 25_000_000, clock frequency in Hz
- DELAY_MS, 10, settle time inserted on a delay entry, in ms
- DELAY_CYCLES, CLK_FREQ/1000*DELAY_MS, derived cycle count; overridable for simulation
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin configuration; sampled only in IDLE or DONE
- rom_addr  output  8  ROM read address (registered)
- rom_data  input  16  ROM entry, valid one clock edge after rom_addr changes; [15:8] register, [7:0] value
- sccb_addr  output  8  register address for the SCCB master (registered)
- sccb_data  output  8  register value for the SCCB master (registered)
- sccb_start  output  1  one-cycle request to the SCCB master (registered)
- sccb_ready  input  1  SCCB master idle; drops after accepting a start, rises when the write completes
- busy  output  1  high from start acceptance until DONE
- done  output  1  high in DONE until the next accepted start or reset

## Operation
- Entry codes: 16'hFFFF = end of table; 16'hFFF0 = delay; any other value = write rom_data[7:0] to register rom_data[15:8].
- States: IDLE, FETCH, SEND, WAIT_BUSY, WAIT_IDLE, DELAY, DONE.
- IDLE: rom_addr=0. On start=1: go FETCH, busy=1.
- FETCH: lasts exactly 2 cycles (one for the ROM to latch, one to see the data). At the end of the 2nd cycle, decode rom_data.
  - FFFF: go DONE.
  - FFF0: load the delay counter with DELAY_CYCLES-1 and go DELAY.
  - Otherwise: register sccb_addr/sccb_data and go SEND.
- SEND: when sccb_ready=1, assert sccb_start for exactly one cycle and go WAIT_BUSY. Hold in SEND while sccb_ready=0.
- WAIT_BUSY: wait for sccb_ready=0, then go WAIT_IDLE.
- WAIT_IDLE: on sccb_ready=1, increment rom_addr and go FETCH.
- DELAY: decrement the counter each cycle. At 0, increment rom_addr and go FETCH.
- Address guard: if rom_addr=255 is processed without an FFFF entry, go DONE after that entry completes. The address does not wrap to 0.
- DONE: busy=0, done=1, sccb_start=0. On start=1: rom_addr=0, done=0, go FETCH (full rerun).
- start while busy=1 is ignored.
- sccb_addr/sccb_data remain stable from SEND until the next entry is decoded.
- Delay counter width: $clog2(DELAY_CYCLES+1).

## Timing
- Reset (rst_n=0 at a rising edge) forces state=IDLE, rom_addr=0, sccb_addr=0, sccb_data=0, sccb_start=0, busy=0, done=0, delay counter=0.
- Reset mid-operation aborts immediately. A write already accepted by the SCCB master is not cancelled here.
- Latency from start sampled (edge E0) to sccb_start high is 3 edges (high during the cycle after E3), provided sccb_ready=1.
- sccb_start is never high for two consecutive cycles and is never asserted while sccb_ready=0.
- Per write entry, minimum cost = 2 (FETCH) + 1 (SEND) + master busy time + 1.
- A delay entry costs 2 (FETCH) + DELAY_CYCLES cycles.
- done rises on the edge following the decode of FFFF.

## Test plan
- Table {1280, FFF0, 1210, FFFF}, DELAY_CYCLES=16, master model busy for 5 cycles -> exactly two sccb_start pulses, (0x12,0x80) then (0x12,0x10). Gap between the end of the first write and the second FETCH equals 16 delay cycles plus FETCH. done=1, busy=0 at end, rom_addr=3.
- sccb_ready held 0 for 40 cycles while in SEND -> no sccb_start pulse. Pulse occurs on the first cycle after sccb_ready returns to 1. sccb_addr/sccb_data stable throughout.
- rst_n=0 for one cycle during WAIT_IDLE of entry 2 -> all outputs return to reset values the next cycle. A subsequent start replays from address 0, first write (0x12,0x80).
- start pulsed repeatedly while busy -> no restart or address change. start pulsed in DONE -> second full pass with identical write sequence.
- Table with 256 write entries and no FFFF -> 256 sccb_start pulses, then done=1. rom_addr stays 255 and never wraps.
- First entry FFFF -> no sccb_start, done=1 exactly 3 edges after start sampled.

Source files
------------

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 configuration ROM from address 0 and issues one SCCB write per entry.
// Delay entries insert a settle time. The end marker, or running off address 255, finishes the walk.
module ov7670_config_sequencer #(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int DELAY_MS     = 10,
  parameter int DELAY_CYCLES = CLK_FREQ/1000*DELAY_MS
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic [7:0]  sccb_addr_o,
  output logic [7:0]  sccb_data_o,
  output logic        sccb_start_o,
  input  logic        sccb_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int CNT_W = $clog2(DELAY_CYCLES+1);
  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_WAIT_BUSY, S_WAIT_IDLE, S_DELAY, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               fetch_ph_q, fetch_ph_d;
  logic [7:0]         rom_addr_q, rom_addr_d;
  logic [7:0]         sccb_addr_q, sccb_addr_d;
  logic [7:0]         sccb_data_q, sccb_data_d;
  logic               sccb_start_q, sccb_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_entry;

  // Address 255 is the final slot; finishing it ends the walk instead of wrapping.
  assign last_entry = (rom_addr_q == 8'hFF);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      fetch_ph_q   <= 1'b0;
      rom_addr_q   <= '0;
      sccb_addr_q  <= '0;
      sccb_data_q  <= '0;
      sccb_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      fetch_ph_q   <= fetch_ph_d;
      rom_addr_q   <= rom_addr_d;
      sccb_addr_q  <= sccb_addr_d;
      sccb_data_q  <= sccb_data_d;
      sccb_start_q <= sccb_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_ph_d   = fetch_ph_q;
    rom_addr_d   = rom_addr_q;
    sccb_addr_d  = sccb_addr_q;
    sccb_data_d  = sccb_data_q;
    sccb_start_d = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        rom_addr_d = '0;
        if (start_i) begin
          state_d    = S_FETCH;
          fetch_ph_d = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      // First cycle lets the ROM register the address; second cycle decodes its data.
      S_FETCH: begin
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          if (rom_data_i == ENTRY_END) begin
            state_d = S_DONE;
          end else if (rom_data_i == ENTRY_DELAY) begin
            cnt_d   = CNT_W'(DELAY_CYCLES-1);
            state_d = S_DELAY;
          end else begin
            sccb_addr_d = rom_data_i[15:8];
            sccb_data_d = rom_data_i[7:0];
            state_d     = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (sccb_ready_i) begin
          sccb_start_d = 1'b1;
          state_d      = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!sccb_ready_i) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (sccb_ready_i) begin
          if (last_entry) begin
            state_d = S_DONE;
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = S_FETCH;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          if (last_entry) begin
            state_d = S_DONE;
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // busy/done follow the state by one edge, so done rises the edge after the end marker decodes.
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (start_i) begin
          rom_addr_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          fetch_ph_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr_o   = rom_addr_q;
  assign sccb_addr_o  = sccb_addr_q;
  assign sccb_data_o  = sccb_data_q;
  assign sccb_start_o = sccb_start_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
